zx_mem_arbiter: RTL and testbench
=================================

// Module: zx_mem_arbiter
// PURPOSE
//  Shares the single byte-wide SDRAM port between three requesters: CPU bus cycles,
//  video character-pattern fetch (refresh-cycle CHR lookups) and the tape DMA writer.
//  Sits between the core's memory decode and the SDRAM controller.
//  Sequences each access as issue -> wait-ready -> ack, with fixed priority plus a DMA anti-starvation guard.
// PARAMETERS
//  STARVE_LIM   4    consecutive non-DMA grants while DMA pending before DMA is forced next
//  TIMEOUT_CYC  64   max cycles in WAIT before access is aborted
//  AW           16   address width
// PORTS
//  clk_sys      in   1    system clock (52 MHz)
//  reset        in   1    synchronous, active-high
//  cpu_req      in   1    CPU access request, held until cpu_ack
//  cpu_we       in   1    1=write, 0=read; stable while cpu_req
//  cpu_addr     in   AW   CPU address
//  cpu_wdata    in   8    CPU write data
//  cpu_ack      out  1    one-cycle completion pulse
//  cpu_rdata    out  8    read data; valid in cpu_ack cycle, held until next cpu_ack
//  vid_req/vid_addr/vid_ack/vid_rdata   video read-only port, same rules as CPU
//  dma_req/dma_addr/dma_wdata/dma_ack   tape DMA write-only port, same rules
//  mem_addr     out  AW   SDRAM address
//  mem_din      out  8    SDRAM write data
//  mem_rd       out  1    one-cycle read strobe
//  mem_we       out  1    one-cycle write strobe
//  mem_dout     in   8    SDRAM read data
//  mem_ready    in   1    SDRAM idle/data-valid
//  busy         out  1    high in any state but IDLE
//  timeout_err  out  1    sticky; set on any timeout, cleared by reset only
// BEHAVIOUR
//  Reset: state IDLE; all acks, mem_rd, mem_we, busy, timeout_err = 0; rdata regs = 8'hFF; starve cnt = 0.
//  FSM IDLE -> ISSUE -> SETTLE -> WAIT -> IDLE.
//   IDLE: if any req and mem_ready=1, grant winner, latch addr/data/we into mem_* regs -> ISSUE.
//   ISSUE: mem_rd or mem_we high exactly 1 cycle -> SETTLE.
//   SETTLE: 1 cycle, mem_ready ignored (controller drops ready here) -> WAIT.
//   WAIT: on mem_ready=1: read captures mem_dout into grantee rdata; grantee ack=1 for 1 cycle -> IDLE.
//  Latency: req seen in IDLE to ack = 4 cycles min (IDLE, ISSUE, SETTLE, WAIT+ack).
//  Priority: CPU > VID > DMA; if starve cnt == STARVE_LIM and dma_req, DMA wins regardless.
//  Starve cnt: +1 per non-DMA grant while dma_req; cleared on DMA grant or dma_req=0; saturates.
//  Timeout: WAIT count reaches TIMEOUT_CYC -> ack grantee, rdata=8'hFF, timeout_err=1, -> IDLE.
//  Req dropped before ack: access still completes; ack suppressed; no rdata update.
//  Back-to-back: new grant evaluated in the cycle after ack; no req sampled in ack cycle.
//  Address width: mem_addr = granted addr unchanged; no wrap or translation done here.
//  Reset mid-access: immediate IDLE, strobes low, no ack emitted.
// CONFIGURATION
//  ZX_ARB_STATS_EN defined: adds out ports stat_cpu, stat_vid, stat_dma (16b each),
//   +1 per completed grant, wrap at 16'hFFFF->0, cleared by reset.
//  Undefined: ports and counters absent; arbitration identical.
// STRUCTURE
//  Package zx_mem_pkg: typedef enum arb_state_t {IDLE,ISSUE,SETTLE,WAIT}; typedef enum
//   requester_t {REQ_NONE,REQ_CPU,REQ_VID,REQ_DMA}; localparam RDATA_DEFAULT = 8'hFF.
//  Sub-module zx_arb_pick: combinational priority + starvation override, returns requester_t.
// TESTING
//  1 CPU read 0x4000, SDRAM model returns 8'h5A after 3 cycles -> mem_rd 1 pulse, cpu_ack, cpu_rdata=5A.
//  2 cpu_req+vid_req+dma_req together -> grant order CPU, VID, DMA; one ack each, no overlap.
//  3 cpu_req held continuously, dma_req high -> DMA granted after exactly 4 CPU grants.
//  4 mem_ready held 0 after issue -> ack at WAIT cycle 64, rdata=FF, timeout_err=1 sticky.
//  5 reset asserted in WAIT -> next cycle IDLE, no ack, mem_rd/mem_we 0, busy 0.
//  6 ZX_ARB_STATS_EN: 3 CPU + 2 DMA accesses -> stat_cpu=3, stat_vid=0, stat_dma=2.

Source files
------------

// File: rtl/zx_mem_pkg.sv
// Shared types for the SDRAM port arbiter: FSM states, requester ids, idle read value.
package zx_mem_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, WAIT} arb_state_t;

  typedef enum logic [1:0] {REQ_NONE, REQ_CPU, REQ_VID, REQ_DMA} requester_t;

  localparam logic [7:0] RDATA_DEFAULT = 8'hFF;

endpackage

// File: rtl/zx_arb_pick.sv
// Combinational winner select: CPU > VID > DMA, with DMA forced once the
// starvation count has reached its limit.
module zx_arb_pick
  import zx_mem_pkg::*;
#(
  parameter int STARVE_LIM = 4,
  parameter int SW         = 3
) (
  input  logic          cpu_req,
  input  logic          vid_req,
  input  logic          dma_req,
  input  logic [SW-1:0] starve_cnt,
  output requester_t    pick
);

  always_comb begin
    if (dma_req && (starve_cnt == SW'(STARVE_LIM))) pick = REQ_DMA;
    else if (cpu_req)                                pick = REQ_CPU;
    else if (vid_req)                                pick = REQ_VID;
    else if (dma_req)                                pick = REQ_DMA;
    else                                             pick = REQ_NONE;
  end

endmodule

// File: rtl/zx_mem_arbiter.sv
// Three-way SDRAM port arbiter (CPU, video CHR fetch, tape DMA): IDLE->ISSUE->SETTLE->WAIT,
// ack registered one cycle after ready/timeout. ZX_ARB_STATS_EN adds per-requester grant counters.
module zx_mem_arbiter
  import zx_mem_pkg::*;
#(
  parameter int STARVE_LIM  = 4,
  parameter int TIMEOUT_CYC = 64,
  parameter int AW          = 16
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic          cpu_ack,
  output logic [7:0]    cpu_rdata,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [7:0]    vid_rdata,
  input  logic          dma_req,
  input  logic [AW-1:0] dma_addr,
  input  logic [7:0]    dma_wdata,
  output logic          dma_ack,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  output logic          mem_rd,
  output logic          mem_we,
  input  logic [7:0]    mem_dout,
  input  logic          mem_ready,
  output logic          busy,
  output logic          timeout_err
`ifdef ZX_ARB_STATS_EN
  ,
  output logic [15:0]   stat_cpu,
  output logic [15:0]   stat_vid,
  output logic [15:0]   stat_dma
`endif
);

  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam int WW = $clog2(TIMEOUT_CYC + 1);

  arb_state_t    state_q, state_d;
  requester_t    grant_q, grant_d, pick;
  logic          we_q, we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]    mem_din_q, mem_din_d;
  logic          mem_rd_q, mem_rd_d, mem_we_q, mem_we_d;
  logic          cpu_ack_q, cpu_ack_d, vid_ack_q, vid_ack_d, dma_ack_q, dma_ack_d;
  logic [7:0]    cpu_rdata_q, cpu_rdata_d, vid_rdata_q, vid_rdata_d;
  logic          done_q, done_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          terr_q, terr_d;
  logic          sel_we;
  logic [7:0]    fin_data;
`ifdef ZX_ARB_STATS_EN
  logic [15:0]   stat_cpu_q, stat_cpu_d, stat_vid_q, stat_vid_d, stat_dma_q, stat_dma_d;
`endif

  zx_arb_pick #(.STARVE_LIM(STARVE_LIM), .SW(SW)) u_pick (
    .cpu_req    (cpu_req),
    .vid_req    (vid_req),
    .dma_req    (dma_req),
    .starve_cnt (starve_q),
    .pick       (pick)
  );

  assign sel_we   = (pick == REQ_DMA) || ((pick == REQ_CPU) && cpu_we);
  assign fin_data = mem_ready ? mem_dout : RDATA_DEFAULT;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    we_d        = we_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    mem_rd_d    = 1'b0;
    mem_we_d    = 1'b0;
    cpu_ack_d   = 1'b0;
    vid_ack_d   = 1'b0;
    dma_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    vid_rdata_d = vid_rdata_q;
    done_d      = 1'b0;
    wcnt_d      = wcnt_q;
    starve_d    = dma_req ? starve_q : '0;
    terr_d      = terr_q;
`ifdef ZX_ARB_STATS_EN
    stat_cpu_d  = stat_cpu_q;
    stat_vid_d  = stat_vid_q;
    stat_dma_d  = stat_dma_q;
`endif
    case (state_q)
      IDLE: begin
        // done_q marks the ack cycle; requests there are stale by definition
        if (!done_q && (pick != REQ_NONE) && mem_ready) begin
          state_d  = ISSUE;
          grant_d  = pick;
          we_d     = sel_we;
          mem_rd_d = !sel_we;
          mem_we_d = sel_we;
          case (pick)
            REQ_CPU: begin mem_addr_d = cpu_addr; mem_din_d = cpu_wdata; end
            REQ_VID: begin mem_addr_d = vid_addr; mem_din_d = 8'h00;     end
            default: begin mem_addr_d = dma_addr; mem_din_d = dma_wdata; end
          endcase
          if (pick == REQ_DMA || !dma_req)       starve_d = '0;
          else if (starve_q != SW'(STARVE_LIM)) starve_d = starve_q + SW'(1);
        end
      end
      ISSUE:  state_d = SETTLE;
      SETTLE: begin
        state_d = WAIT;
        wcnt_d  = WW'(1);
      end
      WAIT: begin
        if (mem_ready || (wcnt_q == WW'(TIMEOUT_CYC))) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (!mem_ready) terr_d = 1'b1;
          case (grant_q)
            REQ_CPU: if (cpu_req) begin
              cpu_ack_d = 1'b1;
              if (!we_q) cpu_rdata_d = fin_data;
            end
            REQ_VID: if (vid_req) begin
              vid_ack_d   = 1'b1;
              vid_rdata_d = fin_data;
            end
            REQ_DMA: if (dma_req) dma_ack_d = 1'b1;
            default: ;
          endcase
`ifdef ZX_ARB_STATS_EN
          case (grant_q)
            REQ_CPU: stat_cpu_d = stat_cpu_q + 16'd1;
            REQ_VID: stat_vid_d = stat_vid_q + 16'd1;
            REQ_DMA: stat_dma_d = stat_dma_q + 16'd1;
            default: ;
          endcase
`endif
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= REQ_NONE;
      we_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= 8'h00;
      mem_rd_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      vid_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= RDATA_DEFAULT;
      vid_rdata_q <= RDATA_DEFAULT;
      done_q      <= 1'b0;
      wcnt_q      <= '0;
      starve_q    <= '0;
      terr_q      <= 1'b0;
`ifdef ZX_ARB_STATS_EN
      stat_cpu_q  <= 16'd0;
      stat_vid_q  <= 16'd0;
      stat_dma_q  <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      we_q        <= we_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      mem_rd_q    <= mem_rd_d;
      mem_we_q    <= mem_we_d;
      cpu_ack_q   <= cpu_ack_d;
      vid_ack_q   <= vid_ack_d;
      dma_ack_q   <= dma_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_rdata_q <= vid_rdata_d;
      done_q      <= done_d;
      wcnt_q      <= wcnt_d;
      starve_q    <= starve_d;
      terr_q      <= terr_d;
`ifdef ZX_ARB_STATS_EN
      stat_cpu_q  <= stat_cpu_d;
      stat_vid_q  <= stat_vid_d;
      stat_dma_q  <= stat_dma_d;
`endif
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_din     = mem_din_q;
  assign mem_rd      = mem_rd_q;
  assign mem_we      = mem_we_q;
  assign cpu_ack     = cpu_ack_q;
  assign vid_ack     = vid_ack_q;
  assign dma_ack     = dma_ack_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign vid_rdata   = vid_rdata_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = terr_q;
`ifdef ZX_ARB_STATS_EN
  assign stat_cpu    = stat_cpu_q;
  assign stat_vid    = stat_vid_q;
  assign stat_dma    = stat_dma_q;
`endif

endmodule

// File: tb/tb_zx_mem_arbiter.sv
// Directed bench for zx_mem_arbiter with a small latency-programmable SDRAM model.
module tb_zx_mem_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, vid_req, dma_req;
  logic [15:0] cpu_addr, vid_addr, dma_addr;
  logic [7:0]  cpu_wdata, dma_wdata, mem_dout;
  logic        cpu_ack, vid_ack, dma_ack, mem_rd, mem_we, mem_ready, busy, timeout_err;
  logic [7:0]  cpu_rdata, vid_rdata, mem_din;
  logic [15:0] mem_addr;
`ifdef ZX_ARB_STATS_EN
  logic [15:0] stat_cpu, stat_vid, stat_dma;
`endif

  zx_mem_arbiter dut (
    .clk_sys(clk_sys), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_ack(dma_ack),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_rd(mem_rd), .mem_we(mem_we),
    .mem_dout(mem_dout), .mem_ready(mem_ready), .busy(busy), .timeout_err(timeout_err)
`ifdef ZX_ARB_STATS_EN
    , .stat_cpu(stat_cpu), .stat_vid(stat_vid), .stat_dma(stat_dma)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  int          tests = 0, fails = 0, cyc = 0, mcnt = 0, lat = 3;
  int          rd_cyc, ack_cyc, nstrobe, overlap, nack;
  bit          hang = 1'b0;
  logic [7:0]  mdata = 8'h00;
  logic [15:0] s_addr;
  logic [7:0]  s_din;
  logic        s_we;
  string       ord;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle; inputs and the SDRAM model move on the falling edge.
  task automatic tick();
    @(negedge clk_sys);
    cyc++;
    if (mem_rd || mem_we) begin
      mem_ready = 1'b0;
      mcnt      = lat;
    end else if (!mem_ready && !hang) begin
      if (mcnt > 1) mcnt--;
      else begin
        mem_ready = 1'b1;
        mem_dout  = mdata;
      end
    end
  endtask

  task automatic serve(input int maxc, input bit cpu_hold);
    int n;
    n = 0; ord = ""; overlap = 0; nstrobe = 0;
    while ((cpu_req || vid_req || dma_req || busy) && n < maxc) begin
      tick();
      n++;
      if (mem_rd || mem_we) begin
        nstrobe++; rd_cyc = cyc; s_addr = mem_addr; s_din = mem_din; s_we = mem_we;
      end
      if (int'(cpu_ack) + int'(vid_ack) + int'(dma_ack) > 1) overlap++;
      if (cpu_ack) begin ord = {ord, "C"}; ack_cyc = cyc; if (!cpu_hold) cpu_req = 1'b0; end
      if (vid_ack) begin ord = {ord, "V"}; ack_cyc = cyc; vid_req = 1'b0; end
      if (dma_ack) begin ord = {ord, "D"}; ack_cyc = cyc; dma_req = 1'b0; cpu_req = 1'b0; end
    end
    chk("serve_bound", 32'(n < maxc), 32'd1);
  endtask

  initial begin
    reset = 1'b1; cpu_req = 0; cpu_we = 0; vid_req = 0; dma_req = 0;
    cpu_addr = 0; vid_addr = 0; dma_addr = 0; cpu_wdata = 0; dma_wdata = 0;
    mem_dout = 8'h00; mem_ready = 1'b1;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_acks", {cpu_ack, vid_ack, dma_ack}, 0);
    chk("rst_strobes", {mem_rd, mem_we}, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_cpu_rdata", cpu_rdata, 8'hFF);
    chk("rst_vid_rdata", vid_rdata, 8'hFF);
    reset = 1'b0;
    tick();

    // 1: single CPU read, data after 3 cycles
    lat = 3; mdata = 8'h5A;
    cpu_addr = 16'h4000; cpu_we = 0; cpu_req = 1;
    serve(20, 0);
    chk("t1_order", 32'(ord == "C"), 1);
    chk("t1_strobes", nstrobe, 1);
    chk("t1_addr", s_addr, 16'h4000);
    chk("t1_is_read", s_we, 0);
    chk("t1_latency", ack_cyc - rd_cyc, 4);
    chk("t1_rdata", cpu_rdata, 8'h5A);

    // 2: all three at once -> CPU, VID, DMA
    mdata = 8'h77; lat = 2;
    cpu_addr = 16'h0100; vid_addr = 16'h1800; dma_addr = 16'hC000; dma_wdata = 8'hE7;
    cpu_req = 1; vid_req = 1; dma_req = 1;
    serve(60, 0);
    chk("t2_order", 32'(ord == "CVD"), 1);
    chk("t2_overlap", overlap, 0);
    chk("t2_strobes", nstrobe, 3);
    chk("t2_dma_addr", s_addr, 16'hC000);
    chk("t2_dma_din", s_din, 8'hE7);
    chk("t2_dma_we", s_we, 1);
    chk("t2_vid_rdata", vid_rdata, 8'h77);
    chk("t2_cpu_rdata", cpu_rdata, 8'h77);

    // 3: CPU hogging, DMA waiting -> DMA forced after 4 CPU grants
    mdata = 8'h11; lat = 1;
    cpu_req = 1; dma_req = 1;
    serve(80, 1);
    chk("t3_order", 32'(ord == "CCCCD"), 1);
    chk("t3_overlap", overlap, 0);
    chk("t3_rdata", cpu_rdata, 8'h11);

    // Request withdrawn mid-access: access completes, no ack, no rdata update
    mdata = 8'h99; lat = 3; cpu_addr = 16'h2222; cpu_req = 1;
    nack = 0; nstrobe = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_rd) begin nstrobe++; cpu_req = 0; end
      if (cpu_ack) nack++;
    end
    chk("drop_strobes", nstrobe, 1);
    chk("drop_no_ack", nack, 0);
    chk("drop_rdata", cpu_rdata, 8'h11);
    chk("drop_idle", busy, 0);

    // 4: SDRAM never ready -> timeout after 64 WAIT cycles
    hang = 1; cpu_addr = 16'h1234; cpu_req = 1;
    serve(100, 0);
    chk("t4_order", 32'(ord == "C"), 1);
    chk("t4_wait_len", ack_cyc - rd_cyc, 66);
    chk("t4_rdata", cpu_rdata, 8'hFF);
    chk("t4_terr", timeout_err, 1);
    hang = 0; mem_ready = 1;
    lat = 1; mdata = 8'h3C; cpu_addr = 16'h0010; cpu_req = 1;
    serve(20, 0);
    chk("t4_sticky", timeout_err, 1);
    chk("t4_next_rdata", cpu_rdata, 8'h3C);

    // 5: reset while in WAIT
    hang = 1; cpu_addr = 16'h5555; cpu_req = 1;
    for (int i = 0; i < 10 && !mem_rd; i++) tick();
    chk("t5_issued", mem_rd, 1);
    tick(); tick();
    chk("t5_in_wait", busy, 1);
    reset = 1; cpu_req = 0;
    tick();
    chk("t5_busy", busy, 0);
    chk("t5_strobes", {mem_rd, mem_we}, 0);
    chk("t5_ack", cpu_ack, 0);
    chk("t5_terr_clr", timeout_err, 0);
    reset = 0; hang = 0; mem_ready = 1;
    nack = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cpu_ack || vid_ack || dma_ack || mem_rd || mem_we) nack++;
    end
    chk("t5_quiet", nack, 0);

    // 6: 3 CPU reads + 2 DMA writes
    lat = 1; mdata = 8'h42;
    for (int i = 0; i < 3; i++) begin
      cpu_addr = 16'(16'h3000 + i); cpu_req = 1;
      serve(20, 0);
    end
    for (int i = 0; i < 2; i++) begin
      dma_addr = 16'(16'h8000 + i); dma_wdata = 8'(i); dma_req = 1;
      serve(20, 0);
    end
    chk("t6_last_dma_addr", s_addr, 16'h8001);
`ifdef ZX_ARB_STATS_EN
    chk("t6_stat_cpu", stat_cpu, 3);
    chk("t6_stat_vid", stat_vid, 0);
    chk("t6_stat_dma", stat_dma, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
